// File: rtl/cc_collatz_pkg.sv
// Shared definitions for the Collatz sequencing controller: FSM states,
// datapath mux select codes and error codes.
package cc_collatz_pkg;

   localparam logic [1:0] SEL_SEED  = 2'b00;
   localparam logic [1:0] SEL_NEXT  = 2'b01;
   localparam logic [1:0] SEL_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ITER,
      ST_DONE,
      ST_ERROR
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'b00,
      ERR_ZERO_SEED  = 2'b01,
      ERR_OVERFLOW   = 2'b10,
      ERR_STEP_LIMIT = 2'b11
   } err_t;

endpackage

// File: rtl/cc_collatz_step.sv
// Combinational Collatz step: halves even values, forms 3v+1 for odd values
// with two guard bits so that an unrepresentable result is flagged.
module cc_collatz_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] value_i,
   output logic [W-1:0] next_o,
   output logic         overflow_o
);

   logic [W+1:0] triple_plus_one;

   always_comb begin
      triple_plus_one = {2'b00, value_i} + {1'b0, value_i, 1'b0} + {{(W+1){1'b0}}, 1'b1};
      next_o          = value_i >> 1;
      overflow_o      = 1'b0;
      if (value_i[0]) begin
         next_o     = triple_plus_one[W-1:0];
         overflow_o = |triple_plus_one[W+1:W];
      end
   end

endmodule

// File: rtl/cc_collatz_controller.sv
// Collatz sequencing controller: owns the working value, step counter and
// error code, and drives the datapath mux select from the current state.
module cc_collatz_controller
   import cc_collatz_pkg::*;
#(
   parameter int DATAWIDTH_BUS           = 8,
   parameter int DATAWIDTH_MUX_SELECTION = 2,
   parameter int DATAWIDTH_STEPS         = 8
) (
   input  logic                               CC_COLLATZCTRL_CLOCK_50,
   input  logic                               CC_COLLATZCTRL_RESET_InHigh,
   input  logic                               CC_COLLATZCTRL_start_In,
   input  logic [DATAWIDTH_BUS-1:0]           CC_COLLATZCTRL_seed_InBUS,
   output logic [DATAWIDTH_MUX_SELECTION-1:0] CC_COLLATZCTRL_muxSelection_OutBUS,
   output logic [DATAWIDTH_BUS-1:0]           CC_COLLATZCTRL_value_OutBUS,
   output logic [DATAWIDTH_STEPS-1:0]         CC_COLLATZCTRL_steps_OutBUS,
   output logic                               CC_COLLATZCTRL_busy_Out,
   output logic                               CC_COLLATZCTRL_done_Out,
   output logic [1:0]                         CC_COLLATZCTRL_error_OutBUS
);

   state_t                     state_q, state_d;
   logic [DATAWIDTH_BUS-1:0]   value_q, value_d;
   logic [DATAWIDTH_STEPS-1:0] steps_q, steps_d;
   err_t                       err_q, err_d;
   logic [1:0]                 sel;
   logic [DATAWIDTH_BUS-1:0]   next_value;
   logic                       next_overflow;

   cc_collatz_step #(.W(DATAWIDTH_BUS)) u_step (
      .value_i    (value_q),
      .next_o     (next_value),
      .overflow_o (next_overflow)
   );

   always_ff @(posedge CC_COLLATZCTRL_CLOCK_50) begin
      if (CC_COLLATZCTRL_RESET_InHigh) begin
         state_q <= ST_IDLE;
         value_q <= '0;
         steps_q <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         steps_q <= steps_d;
         err_q   <= err_d;
      end
   end

   // The step that lands on 1 goes straight to DONE, so no extra ITER cycle is spent.
   always_comb begin
      state_d = state_q;
      value_d = value_q;
      steps_d = steps_q;
      err_d   = err_q;
      sel     = SEL_CLEAR;
      case (state_q)
         ST_IDLE: begin
            value_d = '0;
            steps_d = '0;
            err_d   = ERR_NONE;
            if (CC_COLLATZCTRL_start_In) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            sel     = SEL_SEED;
            value_d = CC_COLLATZCTRL_seed_InBUS;
            steps_d = '0;
            err_d   = ERR_NONE;
            if (CC_COLLATZCTRL_seed_InBUS == '0) begin
               state_d = ST_ERROR;
               err_d   = ERR_ZERO_SEED;
            end else if (CC_COLLATZCTRL_seed_InBUS == DATAWIDTH_BUS'(1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ITER;
            end
         end
         ST_ITER: begin
            sel = SEL_NEXT;
            if (value_q == DATAWIDTH_BUS'(1)) begin
               state_d = ST_DONE;
            end else if (next_overflow) begin
               state_d = ST_ERROR;
               err_d   = ERR_OVERFLOW;
            end else if (steps_q == '1) begin
               state_d = ST_ERROR;
               err_d   = ERR_STEP_LIMIT;
            end else begin
               value_d = next_value;
               steps_d = steps_q + DATAWIDTH_STEPS'(1);
               if (next_value == DATAWIDTH_BUS'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (CC_COLLATZCTRL_start_In) begin
               state_d = ST_LOAD;
               err_d   = ERR_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign CC_COLLATZCTRL_muxSelection_OutBUS = DATAWIDTH_MUX_SELECTION'(sel);
   assign CC_COLLATZCTRL_value_OutBUS        = value_q;
   assign CC_COLLATZCTRL_steps_OutBUS        = steps_q;
   assign CC_COLLATZCTRL_busy_Out            = (state_q == ST_LOAD) || (state_q == ST_ITER);
   assign CC_COLLATZCTRL_done_Out            = (state_q == ST_DONE);
   assign CC_COLLATZCTRL_error_OutBUS        = err_q;

endmodule

// File: tb/tb_cc_collatz_controller.sv
// Self-checking bench for cc_collatz_controller: hand-computed vector table,
// multi-cycle corner sequences and random seeds against an arithmetic model.
module tb_cc_collatz_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] seed;

   logic [1:0] selA, errA, selB, errB;
   logic [7:0] valA, stepsA, valB;
   logic [3:0] stepsB;
   logic       busyA, doneA, busyB, doneB;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int seed;
      int code;
      int value;
      int steps;
      int lat;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   // Full 8-bit step counter instance
   cc_collatz_controller #(.DATAWIDTH_BUS(8), .DATAWIDTH_MUX_SELECTION(2), .DATAWIDTH_STEPS(8)) dutA (
      .CC_COLLATZCTRL_CLOCK_50            (clk),
      .CC_COLLATZCTRL_RESET_InHigh        (rst),
      .CC_COLLATZCTRL_start_In            (start),
      .CC_COLLATZCTRL_seed_InBUS          (seed),
      .CC_COLLATZCTRL_muxSelection_OutBUS (selA),
      .CC_COLLATZCTRL_value_OutBUS        (valA),
      .CC_COLLATZCTRL_steps_OutBUS        (stepsA),
      .CC_COLLATZCTRL_busy_Out            (busyA),
      .CC_COLLATZCTRL_done_Out            (doneA),
      .CC_COLLATZCTRL_error_OutBUS        (errA)
   );

   // Narrow 4-bit step counter instance for the step-limit case
   cc_collatz_controller #(.DATAWIDTH_BUS(8), .DATAWIDTH_MUX_SELECTION(2), .DATAWIDTH_STEPS(4)) dutB (
      .CC_COLLATZCTRL_CLOCK_50            (clk),
      .CC_COLLATZCTRL_RESET_InHigh        (rst),
      .CC_COLLATZCTRL_start_In            (start),
      .CC_COLLATZCTRL_seed_InBUS          (seed),
      .CC_COLLATZCTRL_muxSelection_OutBUS (selB),
      .CC_COLLATZCTRL_value_OutBUS        (valB),
      .CC_COLLATZCTRL_steps_OutBUS        (stepsB),
      .CC_COLLATZCTRL_busy_Out            (busyB),
      .CC_COLLATZCTRL_done_Out            (doneB),
      .CC_COLLATZCTRL_error_OutBUS        (errB)
   );

   // Compare one observed quantity against its expected value
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: walk the Collatz sequence with plain arithmetic
   function automatic void refCollatz(input int s, input int stepBits, output int code,
                                      output int val, output int steps, output int lat,
                                      output int peak);
      int v;
      int n;
      int maxSteps;
      maxSteps = (1 << stepBits) - 1;
      v        = s;
      steps    = 0;
      peak     = s;
      code     = -1;
      lat      = 2;
      if (s == 0) code = 1;
      while (code < 0) begin
         if (v == 1) begin
            code = 0;
            lat  = 2 + steps;
         end else begin
            n = (v % 2 == 0) ? v / 2 : 3 * v + 1;
            if (n > 255) begin
               code = 2;
               lat  = 3 + steps;
            end else if (steps == maxSteps) begin
               code = 3;
               lat  = 3 + steps;
            end else begin
               v = n;
               steps++;
               if (v > peak) peak = v;
            end
         end
      end
      val = v;
   endfunction

   // Pulse start with a seed and follow one DUT until DONE/ERROR (bounded)
   task automatic applyStimulus(input int s, input int which, input int reStartCycle,
                                output int code, output int val, output int steps,
                                output int lat, output int peak, output int doneFlag,
                                output int selOk, output int busyOk);
      int c;
      int sv, ss, sb, sd, se, ssel;
      code = -1; val = -1; steps = -1; lat = -1; peak = 0; doneFlag = -1;
      selOk = 1; busyOk = 1;
      @(negedge clk);
      start = 1'b1;
      seed  = 8'(s);
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (c <= 600 && lat < 0) begin
         if (which == 0) begin
            sv = valA; ss = stepsA; sb = busyA; sd = doneA; se = errA; ssel = selA;
         end else begin
            sv = valB; ss = stepsB; sb = busyB; sd = doneB; se = errB; ssel = selB;
         end
         if (c >= 2 && sv > peak) peak = sv;
         if (sd == 1 || se != 0) begin
            lat = c; code = se; val = sv; steps = ss; doneFlag = sd;
            if (ssel != 3) selOk = 0;
            if (sb != 0) busyOk = 0;
         end else begin
            if (ssel != ((c == 1) ? 0 : 1)) selOk = 0;
            if (sb != 1) busyOk = 0;
         end
         start = (c == reStartCycle);
         if (c == reStartCycle) seed = 8'(s) ^ 8'h5A;
         @(negedge clk);
         c++;
      end
      start = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int code, val, steps, lat, peak, doneFlag, selOk, busyOk;
      int mCode, mVal, mSteps, mLat, mPeak;
      int s;

      vecs[0] = '{6,   0, 1,   8,  10};
      vecs[1] = '{7,   0, 1,   16, 18};
      vecs[2] = '{85,  2, 85,  0,  3};
      vecs[3] = '{0,   1, 0,   0,  2};
      vecs[4] = '{1,   0, 1,   0,  2};
      vecs[5] = '{2,   0, 1,   1,  3};
      vecs[6] = '{3,   0, 1,   7,  9};
      vecs[7] = '{255, 2, 255, 0,  3};
      vecs[8] = '{27,  2, 107, 11, 14};
      vecs[9] = '{254, 2, 127, 1,  4};

      rst = 1'b1; start = 1'b0; seed = 8'd0;
      repeat (3) @(negedge clk);
      checkOutput("reset_value", valA, 0);
      checkOutput("reset_steps", stepsA, 0);
      checkOutput("reset_busy", busyA, 0);
      checkOutput("reset_done", doneA, 0);
      checkOutput("reset_error", errA, 0);
      checkOutput("reset_select", selA, 3);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].seed, 0, 0, code, val, steps, lat, peak, doneFlag, selOk, busyOk);
         $display("[TB] vector seed=%0d code=%0d value=%0d steps=%0d latency=%0d",
                  vecs[i].seed, code, val, steps, lat);
         checkOutput($sformatf("vec%0d_error", i), code, vecs[i].code);
         checkOutput($sformatf("vec%0d_value", i), val, vecs[i].value);
         checkOutput($sformatf("vec%0d_steps", i), steps, vecs[i].steps);
         checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         checkOutput($sformatf("vec%0d_done", i), doneFlag, (vecs[i].code == 0) ? 1 : 0);
         checkOutput($sformatf("vec%0d_select_seq", i), selOk, 1);
         checkOutput($sformatf("vec%0d_busy_seq", i), busyOk, 1);
      end

      applyStimulus(7, 0, 0, code, val, steps, lat, peak, doneFlag, selOk, busyOk);
      checkOutput("seed7_peak", peak, 52);

      applyStimulus(27, 0, 5, code, val, steps, lat, peak, doneFlag, selOk, busyOk);
      checkOutput("restart_ignored_error", code, 2);
      checkOutput("restart_ignored_value", val, 107);
      checkOutput("restart_ignored_steps", steps, 11);
      checkOutput("restart_ignored_latency", lat, 14);

      // start held high: LOAD and DONE alternate for seed 1
      @(negedge clk);
      start = 1'b1;
      seed  = 8'd1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checkOutput($sformatf("held_start_busy_c%0d", c), busyA, (c % 2 == 1) ? 1 : 0);
         checkOutput($sformatf("held_start_done_c%0d", c), doneA, (c % 2 == 0) ? 1 : 0);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);

      // reset in the middle of ITER for seed 7, after five steps
      start = 1'b1;
      seed  = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("midrun_steps_before_reset", stepsA, 5);
      checkOutput("midrun_value_before_reset", valA, 52);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrun_reset_value", valA, 0);
      checkOutput("midrun_reset_steps", stepsA, 0);
      checkOutput("midrun_reset_busy", busyA, 0);
      checkOutput("midrun_reset_error", errA, 0);
      checkOutput("midrun_reset_select", selA, 3);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(7, 1, 0, code, val, steps, lat, peak, doneFlag, selOk, busyOk);
      refCollatz(7, 4, mCode, mVal, mSteps, mLat, mPeak);
      checkOutput("steplimit_error", code, 3);
      checkOutput("steplimit_steps", steps, 15);
      checkOutput("steplimit_value", val, mVal);
      checkOutput("steplimit_latency", lat, mLat);
      checkOutput("steplimit_done", doneFlag, 0);

      for (int i = 0; i < 40; i++) begin
         s = (i < 2) ? i : int'($urandom_range(0, 255));
         refCollatz(s, 8, mCode, mVal, mSteps, mLat, mPeak);
         applyStimulus(s, 0, 0, code, val, steps, lat, peak, doneFlag, selOk, busyOk);
         checkOutput($sformatf("rand%0d_seed%0d_error", i, s), code, mCode);
         checkOutput($sformatf("rand%0d_seed%0d_value", i, s), val, mVal);
         checkOutput($sformatf("rand%0d_seed%0d_steps", i, s), steps, mSteps);
         checkOutput($sformatf("rand%0d_seed%0d_latency", i, s), lat, mLat);
         checkOutput($sformatf("rand%0d_seed%0d_peak", i, s), peak, mPeak);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
